// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: opcode encoding, sequencer states, datapath width,
// and a magnitude helper for the signed operations.
package ctldefine;

    localparam int unsigned MDU_W = 32;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic [MDU_W-1:0] mag(input logic [MDU_W-1:0] v, input logic sgn);
        return (sgn & v[MDU_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-divide iteration on an unsigned
// remainder:quotient pair.
module mdu_div_step
    import ctldefine::*;
(
    input  logic [MDU_W-1:0] rem,
    input  logic [MDU_W-1:0] quo,
    input  logic [MDU_W-1:0] dvs,
    output logic [MDU_W-1:0] rem_n,
    output logic [MDU_W-1:0] quo_n
);

    logic [MDU_W:0]   shifted;
    logic             ge;
    logic [MDU_W-1:0] sub;

    always_comb begin
        shifted = {rem, quo[MDU_W-1]};
        ge      = shifted >= {1'b0, dvs};
        // When ge holds the true difference is below dvs, so 32 bits suffice.
        sub     = shifted[MDU_W-1:0] - dvs;
        rem_n   = ge ? sub : shifted[MDU_W-1:0];
        quo_n   = {quo[MDU_W-2:0], ge};
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer with HI/LO registers for the 5-stage pipeline.
// Optional macro MDU_ABORT_EN adds an abort input that cancels in-flight ops.
module mdu_ctrl
    import ctldefine::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MDU_ABORT_EN
    input  logic        abort,
`endif
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall_md
);

    localparam logic [4:0] MUL_INIT = 5'(MULT_LAT - 1);
    localparam logic [4:0] DIV_INIT = 5'(DIV_ITER - 1);

    mdu_state_e       state, state_n;
    logic [4:0]       cnt, cnt_n;
    logic [MDU_W-1:0] a_lat, a_lat_n, b_lat, b_lat_n;
    logic [63:0]      prod, prod_n;
    logic [MDU_W-1:0] rem, rem_n, quo, quo_n;
    logic [MDU_W-1:0] step_rem, step_quo;
    logic             q_neg, q_neg_n, r_neg, r_neg_n, div0, div0_n;
    logic [31:0]      hi_n, lo_n;
    logic             busy_n, done_n;
    logic             sgn, go;
    logic [63:0]      ext_a, ext_b;

    mdu_div_step u_step (
        .rem   (rem),
        .quo   (quo),
        .dvs   (b_lat),
        .rem_n (step_rem),
        .quo_n (step_quo)
    );

    assign stall_md = md_use_d & (busy | (start & is_muldiv(op)));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_lat_n = a_lat;
        b_lat_n = b_lat;
        prod_n  = prod;
        rem_n   = rem;
        quo_n   = quo;
        q_neg_n = q_neg;
        r_neg_n = r_neg;
        div0_n  = div0;
        hi_n    = hi;
        lo_n    = lo;
        busy_n  = busy;
        done_n  = 1'b0;
        sgn     = (op == MDU_MULT) || (op == MDU_DIV);
        ext_a   = {{32{sgn & a[31]}}, a};
        ext_b   = {{32{sgn & b[31]}}, b};
`ifdef MDU_ABORT_EN
        go      = start & ~abort;
`else
        go      = start;
`endif

        case (state)
            S_IDLE: begin
                if (go) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            a_lat_n = a;
                            b_lat_n = b;
                            prod_n  = ext_a * ext_b;
                            cnt_n   = MUL_INIT;
                            busy_n  = 1'b1;
                            state_n = S_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            a_lat_n = a;
                            b_lat_n = mag(b, sgn);
                            rem_n   = '0;
                            quo_n   = mag(a, sgn);
                            q_neg_n = sgn & (a[31] ^ b[31]);
                            r_neg_n = sgn & a[31];
                            div0_n  = (b == '0);
                            cnt_n   = DIV_INIT;
                            busy_n  = 1'b1;
                            state_n = S_DIV;
                        end
                        MDU_MTHI: hi_n = a;
                        MDU_MTLO: lo_n = a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt == '0) begin
                    {hi_n, lo_n} = prod;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - 5'd1;
                end
            end
            S_DIV: begin
                rem_n = step_rem;
                quo_n = step_quo;
                if (cnt == '0) state_n = S_FIX;
                else           cnt_n   = cnt - 5'd1;
            end
            S_FIX: begin
                // Divide by zero bypasses sign correction and reports the raw dividend.
                if (div0) begin
                    lo_n = '1;
                    hi_n = a_lat;
                end else begin
                    lo_n = q_neg ? -quo : quo;
                    hi_n = r_neg ? -rem : rem;
                end
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

`ifdef MDU_ABORT_EN
        if (abort && state != S_IDLE) begin
            hi_n    = hi;
            lo_n    = lo;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            state_n = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_lat <= '0;
            b_lat <= '0;
            prod  <= '0;
            rem   <= '0;
            quo   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            div0  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            a_lat <= a_lat_n;
            b_lat <= b_lat_n;
            prod  <= prod_n;
            rem   <= rem_n;
            quo   <= quo_n;
            q_neg <= q_neg_n;
            r_neg <= r_neg_n;
            div0  <= div0_n;
            hi    <= hi_n;
            lo    <= lo_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default build, abort feature off).
module tb_mdu_ctrl;
    import ctldefine::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        md_use_d = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done, stall_md;

    int checks = 0;
    int failures = 0;

    mdu_ctrl #(.MULT_LAT(5), .DIV_ITER(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .md_use_d (md_use_d),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .stall_md (stall_md)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(start && busy)) else begin
                failures++;
                $error("FAIL start_while_busy obs=1 exp=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    int  n;
    int  done_seen;
    logic stall_all;

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_stall", 64'(stall_md), 64'h0);
        rst = 1'b0;

        // mult -3 * 7
        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_idle(n);
        chk("mult_busy_cycles", 64'(n), 64'd5);
        chk("mult_done", 64'(done), 64'h1);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        // multu 0xFFFFFFFF * 2
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        chk("multu_busy_cycles", 64'(n), 64'd5);
        chk("multu_done", 64'(done), 64'h1);
        chk("multu_hi", 64'(hi), 64'h1);
        chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        // div -7 / 2 with a D-stage HI/LO user held throughout
        @(negedge clk);
        md_use_d = 1'b1;
        start = 1'b1; op = MDU_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
        #1;
        chk("div_stall_issue", 64'(stall_md), 64'h1);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        stall_all = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            if (!stall_md) stall_all = 1'b0;
            n++;
            @(negedge clk);
        end
        chk("div_stall_busy", 64'(stall_all), 64'h1);
        chk("div_busy_cycles", 64'(n), 64'd33);
        chk("div_done", 64'(done), 64'h1);
        chk("div_stall_done", 64'(stall_md), 64'h0);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        md_use_d = 1'b0;

        // mtlo: single-edge write, no busy/done
        issue(MDU_MTLO, 32'd5, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'd5);
        chk("mtlo_hi_kept", 64'(hi), 64'hFFFF_FFFF);
        chk("mtlo_busy", 64'(busy), 64'h0);
        chk("mtlo_done", 64'(done), 64'h0);

        // divu by zero
        issue(MDU_DIVU, 32'd100, 32'd0);
        wait_idle(n);
        chk("div0_busy_cycles", 64'(n), 64'd33);
        chk("div0_done", 64'(done), 64'h1);
        chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(hi), 64'd100);

        // signed overflow: 0x80000000 / -1
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("ovf_busy_cycles", 64'(n), 64'd33);
        chk("ovf_lo", 64'(lo), 64'h8000_0000);
        chk("ovf_hi", 64'(hi), 64'h0);

        // mthi
        issue(MDU_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_lo_kept", 64'(lo), 64'h8000_0000);

        // reserved opcode: no effect
        issue(3'd7, 32'hDEAD_BEEF, 32'h1);
        chk("rsv_hi", 64'(hi), 64'h1234_5678);
        chk("rsv_lo", 64'(lo), 64'h8000_0000);
        chk("rsv_busy", 64'(busy), 64'h0);

        // reset in the middle of a divide
        issue(MDU_DIV, 32'd50, 32'd7);
        repeat (9) @(negedge clk);
        chk("mid_busy_before", 64'(busy), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_hi", 64'(hi), 64'h0);
        chk("midrst_lo", 64'(lo), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_done", 64'(done), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("midrst_no_done", 64'(done_seen), 64'h0);
        chk("midrst_hi_after", 64'(hi), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer for the multiply/divide unit and HI/LO registers of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Runs multi-cycle operations: fixed-latency multiply, iterative restoring divide.
- Raises a stall request that the hazard unit ORs into its global stall whenever a D-stage instruction touches HI/LO while the unit is busy.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (legal range 1..16).
- DIV_ITER, 32, divide iterations, one quotient bit per cycle; fixed to the data width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  E-stage instruction is an MDU op; qualified by op.
- op  in  3  MDU opcode; encoding in the shared package.
- a  in  32  forwarded rs value (E stage).
- b  in  32  forwarded rt value (E stage).
- md_use_d  in  1  D-stage instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  multi-cycle operation in flight.
- done  out  1  one-cycle pulse; HI/LO updated this cycle.
- stall_md  out  1  stall request to the hazard unit.

Behaviour:
- Reset (async, any state): state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0, operand latches=0.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start + MULT/MULTU:
  - Latch a, b and signedness.
  - Compute the 64-bit product into an internal register on the same edge.
  - Go to MUL with cnt=MULT_LAT-1.
- MUL:
  - Decrement cnt each cycle.
  - When cnt==0: write {hi,lo}=product, go to IDLE, pulse done the next cycle.
  - busy is high for exactly MULT_LAT cycles.
- IDLE + start + DIV/DIVU:
  - Latch |a| and |b| (signed) or raw values (unsigned).
  - Record quotient sign (a[31]^b[31]) and remainder sign (a[31]) for the signed case.
  - Go to DIV with cnt=DIV_ITER-1.
- DIV:
  - One restoring step per cycle: shift the remainder:quotient pair left, trial-subtract the divisor, set the quotient bit if non-negative.
  - When cnt==0, go to FIX.
- FIX:
  - Apply sign correction (negate quotient/remainder per the recorded signs).
  - Write lo=quotient, hi=remainder; go to IDLE.
  - Total divide busy time = DIV_ITER+1 = 33 cycles.
- Divide by zero (b==0): still takes the full 33 cycles. Result is lo=32'hFFFF_FFFF, hi=a (original a, uncorrected). Deterministic; no exception raised.
- Signed overflow (a=32'h8000_0000, b=-1): lo=32'h8000_0000, hi=0.
- MTHI/MTLO in IDLE: single-cycle write of hi (or lo) from a at the next edge. No busy, no done.
- start while busy:
  - Ignored. The hazard unit guarantees this cannot occur, because stall_md holds the MDU instruction in D.
  - The bench checks, via assertion, that this is never attempted.
- stall_md = md_use_d & (busy | (start & op ∈ {MULT,MULTU,DIV,DIVU})). Purely combinational from registered state plus inputs.
- mfhi/mflo issued the cycle done is high reads the new HI/LO; there is no extra bypass.
- op=NONE or a reserved code with start=1: no effect.
- busy is a registered output; done is a registered one-cycle pulse.

Optional Feature:
- Macro MDU_ABORT_EN adds input abort (1 bit, from M-stage exception/flush).
- With the macro:
  - abort=1 in MUL/DIV/FIX returns to IDLE at the next edge, leaving hi/lo unchanged; no done pulse.
  - abort and start in the same IDLE cycle: the start is dropped.
  - abort has no effect on MTHI/MTLO already committed.
- Without the macro: the port is absent and operations always complete.

Decomposition:
- Shared package ctldefine holds:
  - MDU op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 reserved.
  - State encoding for IDLE/MUL/DIV/FIX.
  - Constants MDU_W=32.
- Sub-module mdu_div_step: one combinational restoring-divide iteration. Inputs are remainder, quotient and divisor; outputs are the next remainder and quotient. Instantiated once inside mdu_ctrl.

Test Plan:
- mult a=-3, b=7 → busy high for 5 cycles, then done; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
- multu a=32'hFFFF_FFFF, b=2 → hi=1, lo=32'hFFFF_FFFE after 5 cycles.
- div a=-7, b=2 → 33 busy cycles; lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
- divu a=100, b=0 → 33 cycles; lo=32'hFFFF_FFFF, hi=100.
- Hold md_use_d=1 throughout a div started at cycle 0 → stall_md=1 from cycle 0 through the last busy cycle, 0 on the done cycle; mtlo a=5 afterwards → lo=5 next edge, busy stays 0.
- Assert rst mid-DIV (cycle 10) → hi=lo=0, busy=0 immediately, no done.
- With MDU_ABORT_EN: abort during MUL cycle 2 → IDLE next edge, hi/lo unchanged, done never pulses.
